// File: rtl/sound_spi_pkg.sv
// Shared constants and state encoding for the sound subsystem SPI slave.
package sound_spi_pkg;
  localparam int unsigned SPI_DW        = 8;
  localparam int unsigned SCK_RATIO_MIN = 8;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } spi_state_t;
endpackage

// File: rtl/sound_spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin with edge strobes.
module sound_spi_sync_edge
  import sound_spi_pkg::*;
#(
  parameter int unsigned STAGES  = 3,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr_q;
  logic              prev_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      sr_q   <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sr_q   <= {sr_q[STAGES-2:0], d};
      prev_q <= sr_q[STAGES-1];
    end
  end

  assign level = sr_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/sound_spi_slave.sv
// Mode-0 SPI slave, oversampled in ACLK; RX/TX valid/ready streams.
// Define SPI_RX_FIFO_EN to replace the RX holding register with a FWFT FIFO.
module sound_spi_slave
  import sound_spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = SPI_DW,
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  SCK,
  input  logic                  SSEL,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_VALID,
  input  logic                  RX_READY,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  TX_VALID,
  output logic                  TX_READY,
  output logic                  RX_OVERRUN,
  output logic                  FRAME_ERR,
  output logic                  BUSY
);
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  if (SYNC_STAGES < 2 || RX_FIFO_DEPTH < 2 ||
      (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_cfg_err
    $error("sound_spi_slave: bad SYNC_STAGES or RX_FIFO_DEPTH");
  end

  logic sck_lvl, sck_rise, sck_fall;
  logic ssel_lvl, ssel_rise, ssel_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic edges_unused;

  sound_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .ACLK(ACLK), .ARESETN(ARESETN), .d(SCK),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  sound_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ssel (
    .ACLK(ACLK), .ARESETN(ARESETN), .d(SSEL),
    .level(ssel_lvl), .rise(ssel_rise), .fall(ssel_fall)
  );
  sound_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .ACLK(ACLK), .ARESETN(ARESETN), .d(MOSI),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );
  assign edges_unused = ^{sck_lvl, mosi_rise, mosi_fall};

  spi_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic                  push_q, push_d;
  logic                  miso_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                  tx_load;

  // SSEL level is only trusted once the chain holds pin samples, not reset ones.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    push_d    = 1'b0;
    tx_load   = 1'b0;
    FRAME_ERR = 1'b0;
    unique case (state_q)
      WAIT_IDLE: begin
        if (prime_q[SYNC_STAGES-1] && ssel_lvl) state_d = IDLE;
      end
      IDLE: begin
        if (ssel_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          tx_load = 1'b1;
        end
      end
      SHIFT: begin
        if (ssel_rise) begin
          state_d   = IDLE;
          cnt_d     = '0;
          FRAME_ERR = (cnt_q != '0);
        end else if (sck_rise) begin
          rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], mosi_lvl};
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d  = '0;
            push_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (sck_fall) begin
          if (cnt_q != '0) tx_sh_d = tx_sh_q << 1;
          else             tx_load = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
    if (tx_load) tx_sh_d = TX_VALID ? TX_DATA : '0;
  end

  assign TX_READY = tx_load & TX_VALID;
  assign BUSY     = (state_q == SHIFT);
  assign MISO     = miso_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      rx_sh_q <= '0;
      tx_sh_q <= '0;
      push_q  <= 1'b0;
      miso_q  <= 1'b0;
      prime_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_sh_q <= rx_sh_d;
      tx_sh_q <= tx_sh_d;
      push_q  <= push_d;
      miso_q  <= (state_d == SHIFT) ? tx_sh_q[DATA_WIDTH-1] : 1'b0;
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // rx_sh_q still holds the completed word while push_q is high.
`ifdef SPI_RX_FIFO_EN
  localparam int unsigned AW  = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned NW  = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [RX_FIFO_DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [NW-1:0]         num_q;
  logic                  pop, full, wr_en;

  assign pop        = RX_VALID & RX_READY;
  assign full       = (num_q == NW'(RX_FIFO_DEPTH));
  assign wr_en      = push_q & (~full | pop);
  assign RX_OVERRUN = push_q & full & ~pop;
  assign RX_VALID   = (num_q != '0);
  assign RX_DATA    = RX_VALID ? mem_q[rd_q] : '0;

  always_ff @(posedge ACLK) begin
    if (wr_en) mem_q[wr_q] <= rx_sh_q;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_q  <= '0;
      rd_q  <= '0;
      num_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      num_q <= num_q + NW'(wr_en) - NW'(pop);
    end
  end
`else
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  pop;

  assign pop        = rx_valid_q & RX_READY;
  assign RX_OVERRUN = push_q & rx_valid_q & ~RX_READY;
  assign RX_VALID   = rx_valid_q;
  assign RX_DATA    = rx_data_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (push_q && (!rx_valid_q || pop)) begin
      rx_data_q  <= rx_sh_q;
      rx_valid_q <= 1'b1;
    end else if (pop) begin
      rx_valid_q <= 1'b0;
    end
  end
`endif
endmodule

// File: doc/sound_spi_slave.md
Name: sound_spi_slave

Overview:
- SPI slave (mode 0, CPOL=0/CPHA=0, MSB first) for the sound subsystem. It receives command/volume bytes from an external SPI master and returns status bytes on MISO.
- Runs entirely in the ACLK domain. SCK, SSEL and MOSI are oversampled through synchronizers, so no SCK-clocked logic exists.
- Received bytes are presented on a valid/ready stream to the sound register block. Transmit bytes are taken from a valid/ready stream.

Parameters:
- DATA_WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 3, synchronizer depth on SCK/SSEL/MOSI (minimum 2).
- RX_FIFO_DEPTH, 4, entries in the optional receive FIFO (power of 2; used only with SPI_RX_FIFO_EN).

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  synchronous active-low reset.
- SCK  in  1  SPI clock from master, asynchronous to ACLK; period must be at least 8 ACLK periods.
- SSEL  in  1  slave select, active-low, asynchronous.
- MOSI  in  1  master-out data, asynchronous.
- MISO  out  1  slave-out data; driven 0 when deselected (no tristate inside the block).
- RX_DATA  out  DATA_WIDTH  received word.
- RX_VALID  out  1  RX_DATA valid.
- RX_READY  in  1  consumer accepts RX_DATA.
- TX_DATA  in  DATA_WIDTH  next word to send.
- TX_VALID  in  1  TX_DATA available.
- TX_READY  out  1  one-cycle pulse: TX_DATA captured into the shifter.
- RX_OVERRUN  out  1  one-cycle pulse: received word dropped.
- FRAME_ERR  out  1  one-cycle pulse: SSEL deasserted mid-word.
- BUSY  out  1  high while in SHIFT.

Behaviour:
- **Reset:** ARESETN is synchronous active-low on ACLK. In reset:
  - MISO=0, RX_DATA=0, RX_VALID=0, TX_READY=0, RX_OVERRUN=0, FRAME_ERR=0, BUSY=0.
  - Synchronizer flops reset to SCK=0, SSEL=1, MOSI=0.
  - State=WAIT_IDLE, bit_cnt=0.
- **Synchronization and edge detect:** each input passes SYNC_STAGES flops. Edges are detected by comparing the last two stages:
  - sck_rise = prev 0, now 1; sck_fall = prev 1, now 0.
  - ssel_assert = 1 to 0; ssel_deassert = 0 to 1.
- **State WAIT_IDLE:** go to IDLE when synced SSEL=1. This prevents joining a frame already in progress at reset release.
- **State IDLE:** on ssel_assert go to SHIFT with bit_cnt=0.
  - If TX_VALID, load tx_sh=TX_DATA and pulse TX_READY in that cycle.
  - Otherwise load tx_sh=0.
  - SCK edges in IDLE are ignored.
- **State SHIFT:** BUSY=1 and MISO=tx_sh[MSB].
  - On sck_rise: rx_sh={rx_sh[DATA_WIDTH-2:0], mosi_sync}, bit_cnt+1.
  - When bit_cnt reaches DATA_WIDTH: the word is complete, bit_cnt returns to 0, and the word is pushed to the RX output (same cycle as that sck_rise).
  - On sck_fall with bit_cnt≠0: tx_sh shifts left by 1.
  - On sck_fall with bit_cnt=0 (word boundary, multi-word frame): reload tx_sh from TX_DATA with a TX_READY pulse if TX_VALID, else load 0.
- **Leaving SHIFT on ssel_deassert:**
  - bit_cnt≠0: pulse FRAME_ERR and discard the partial word.
  - Always: go to IDLE, MISO=0.
  - ssel_deassert takes priority over an SCK edge detected in the same cycle.
- **RX output, no FIFO:** single holding register.
  - Push with RX_VALID=0: RX_DATA=rx word; RX_VALID=1 on the next ACLK.
  - Push while RX_VALID=1 and RX_READY=0: keep the old word, drop the new one, pulse RX_OVERRUN.
  - Push in the same cycle as an RX_VALID&RX_READY handshake: load the new word, RX_VALID stays 1, no overrun.
  - RX_VALID clears after a handshake when there is no simultaneous push.
- **Latency:**
  - 8th SCK rising edge at pin to RX_VALID: SYNC_STAGES+2 ACLK cycles.
  - SCK falling edge at pin to MISO change: SYNC_STAGES+2 ACLK cycles.
- **TX underrun:** no TX_VALID at a load point sends 0x00; no error is flagged.

Optional Feature:
- Macro SPI_RX_FIFO_EN.
- **Defined:** the RX holding register is replaced by an RX_FIFO_DEPTH-entry FIFO with first-word fall-through.
  - RX_DATA shows the head entry; RX_VALID means not empty.
  - A push when full drops the word and pulses RX_OVERRUN.
  - Simultaneous push and pop when full succeeds.
- **Undefined:** single holding register as described above.

Decomposition:
- Package sound_spi_pkg:
  - DATA_WIDTH default.
  - State encoding constants: WAIT_IDLE, IDLE, SHIFT.
  - Minimum SCK/ACLK ratio constant (8).
- Sub-module sound_spi_sync_edge: SYNC_STAGES-flop synchronizer with rise/fall outputs, instantiated for SCK, SSEL and MOSI (MOSI uses the level only).

Test Plan:
- **Single byte:** SCK period 60 ACLK, SSEL low, master sends 0xA5 MSB first, RX_READY=1 → one RX_VALID pulse with RX_DATA=0xA5, FRAME_ERR=0.
- **TX path:** TX_DATA=0x3C, TX_VALID=1 before SSEL falls → TX_READY pulses once; master samples MISO=0,0,1,1,1,1,0,0 on SCK rises.
- **Multi-byte frame with stalled consumer:** frame 0x11,0x22, RX_READY=0 →
  - no FIFO: RX_DATA=0x11 held, one RX_OVERRUN pulse;
  - with SPI_RX_FIFO_EN: both words delivered in order, no overrun.
- **Abort:** SSEL deasserted after 5 SCK rises → one FRAME_ERR pulse, no RX_VALID; the next full byte 0x5A is received correctly.
- **Reset mid-frame:** ARESETN pulsed low while SSEL is low and after 3 bits → after release no RX_VALID until SSEL goes high then low; the following byte 0xFF is received as 0xFF.
- **SCK while deselected:** SSEL=1, toggle SCK 16 times with MOSI toggling → MISO stays 0, RX_VALID stays 0, BUSY stays 0.
